// File: rtl/core_pkg.sv
// Shared pipeline-control definitions: FSM state encodings, register constants, default mul/div latency.
package core_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MD_BUSY = 1'b1;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int unsigned MD_LATENCY_DEF = 4;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the ID sources and a load in EX.
module load_use_detect
  import core_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_MemRead,
  output logic       hazard
);

  always_comb begin
    hazard = ex_MemRead && (ex_rd != REG_X0) &&
             ((id_uses_rs1 && (ex_rd == id_rs1)) ||
              (id_uses_rs2 && (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use bubble, fixed-latency mul/div freeze, EX redirect flush.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_MemRead,
  input  logic       ex_md_valid,
  input  logic       ex_redirect,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_bubble,
  output logic       md_done,
  output logic       md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             load_use;
  logic             md_start;
  logic             md_last;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_MemRead  (ex_MemRead),
    .hazard      (load_use)
  );

  always_comb begin
    md_start = (state == ST_IDLE) && ex_md_valid && !ex_redirect;
    md_last  = (state == ST_MD_BUSY) && (cnt == CNT_W'(MD_LATENCY - 1));
  end

  // The IDLE entry cycle is occupancy cycle 0, so MD_BUSY starts counting at 1
  // and the op leaves EX after exactly MD_LATENCY cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md_start) begin
            state <= ST_MD_BUSY;
            cnt   <= CNT_W'(1);
          end
        end
        default: begin
          if (md_last) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Outputs are forced low while rst is held so the pipeline sees no stray control.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    md_done       = 1'b0;
    md_busy       = 1'b0;
    if (!rst) begin
      if (state == ST_IDLE) begin
        if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_md_valid) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end else begin
        md_busy = 1'b1;
        if (md_last) begin
          md_done = 1'b1;
        end else begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_stall)    stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule
